// File: rtl/reflet_irq_ctrl_pkg.sv
// Shared constants and register-offset encoding for the reflet interrupt controller.
package reflet_irq_ctrl_pkg;

  localparam int unsigned IrqNbLines = 4;
  localparam int unsigned NumRegs    = 5;

  typedef enum logic [2:0] {
    RegEnable   = 3'd0,
    RegMode     = 3'd1,
    RegPolarity = 3'd2,
    RegPending  = 3'd3,
    RegRaw      = 3'd4
  } reg_off_e;

endpackage

// File: rtl/reflet_irq_sync.sv
// Width-bit, Stages-deep flip-flop synchroniser with asynchronous active-high reset.
module reflet_irq_sync #(
  parameter int unsigned Width  = 4,
  parameter int unsigned Stages = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Stages-1:0][Width-1:0] chain_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[Stages-2:0], d_i};
    end
  end

  assign q_o = chain_q[Stages-1];

endmodule

// File: rtl/reflet_irq_ctrl.sv
// Memory-mapped interrupt-source controller: synchronised request lines, per-line polarity,
// edge/level mode and enable, sticky write-1-to-clear pending flags driving ext_int.
module reflet_irq_ctrl
  import reflet_irq_ctrl_pkg::*;
#(
  parameter int unsigned          WordSize   = 16,
  parameter logic [WordSize-1:0]  BaseAddr   = 16'hFFF0,
  parameter int unsigned          SyncStages = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [WordSize-1:0]   addr_i,
  input  logic [WordSize-1:0]   data_in_i,
  input  logic                  write_en_i,
  output logic [WordSize-1:0]   data_out_o,
  input  logic [IrqNbLines-1:0] irq_in_i,
  output logic [IrqNbLines-1:0] ext_int_o
);

  logic [IrqNbLines-1:0] en_q, mode_q, pol_q, pend_q, pend_d, s_prev_q;
  logic [IrqNbLines-1:0] sync_lvl, s, rise, w1c, rdata;
  logic [WordSize-1:0]   data_q, data_d;
  logic                  sel, wr;
  reg_off_e              off;

  reflet_irq_sync #(
    .Width  (IrqNbLines),
    .Stages (SyncStages)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (reset_i),
    .d_i   (irq_in_i),
    .q_o   (sync_lvl)
  );

  assign s    = sync_lvl ^ pol_q;
  assign rise = s & ~s_prev_q;

  // Exact byte-address match only; misaligned or out-of-range addresses never select.
  always_comb begin
    sel = 1'b0;
    off = RegEnable;
    for (int k = 0; k < NumRegs; k++) begin
      if (addr_i == WordSize'(BaseAddr + k * (WordSize / 8))) begin
        sel = 1'b1;
        off = reg_off_e'(k[2:0]);
      end
    end
  end

  assign wr  = write_en_i & sel;
  assign w1c = (wr && off == RegPending) ? data_in_i[IrqNbLines-1:0] : '0;

  // Edge lines: sticky, set beats clear. Level lines: follow s every cycle.
  assign pend_d = (mode_q & ((pend_q & ~w1c) | rise)) | (~mode_q & s);

  always_comb begin
    rdata = '0;
    case (off)
      RegEnable:   rdata = en_q;
      RegMode:     rdata = mode_q;
      RegPolarity: rdata = pol_q;
      RegPending:  rdata = pend_q;
      RegRaw:      rdata = s;
      default:     rdata = '0;
    endcase
    data_d = '0;
    if (sel && !write_en_i) begin
      data_d[IrqNbLines-1:0] = rdata;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      en_q     <= '0;
      mode_q   <= '0;
      pol_q    <= '0;
      pend_q   <= '0;
      s_prev_q <= '0;
      data_q   <= '0;
    end else begin
      if (wr && off == RegEnable)   en_q   <= data_in_i[IrqNbLines-1:0];
      if (wr && off == RegMode)     mode_q <= data_in_i[IrqNbLines-1:0];
      if (wr && off == RegPolarity) pol_q  <= data_in_i[IrqNbLines-1:0];
      pend_q   <= pend_d;
      s_prev_q <= s;
      data_q   <= data_d;
    end
  end

  assign ext_int_o  = pend_q & en_q;
  assign data_out_o = data_q;

endmodule

// File: tb/tb_reflet_irq_ctrl.sv
// Self-checking bench for reflet_irq_ctrl: directed scenarios plus randomized traffic vs a model.
module tb_reflet_irq_ctrl;

  localparam int unsigned W    = 16;
  localparam logic [15:0] Base = 16'hFFF0;
  localparam int unsigned St   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, wdata, rdata;
  logic        we;
  logic [3:0]  irq, ext;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0]  m_en, m_mode, m_pol, m_pend, m_sprev;
  logic [15:0] m_data;
  logic [3:0]  m_hist[$];

  always #5 clk = ~clk;

  reflet_irq_ctrl #(
    .WordSize   (W),
    .BaseAddr   (Base),
    .SyncStages (St)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .addr_i     (addr),
    .data_in_i  (wdata),
    .write_en_i (we),
    .data_out_o (rdata),
    .irq_in_i   (irq),
    .ext_int_o  (ext)
  );

  function automatic logic [15:0] a_of(int k);
    return Base + 16'(k * 2);
  endfunction

  task automatic model_reset();
    m_en = '0; m_mode = '0; m_pol = '0; m_pend = '0; m_sprev = '0; m_data = '0;
    m_hist = {};
    for (int i = 0; i < St; i++) m_hist.push_back(4'h0);
  endtask

  // Advance one clock; model computes from pre-edge inputs, commits after the edge.
  task automatic tick();
    logic [3:0]  s, w1c, nxt, irq_smp;
    logic [15:0] rd;
    bit          sel;
    int          k;
    s = m_hist[0] ^ m_pol;
    irq_smp = irq;
    sel = 0; k = 0;
    for (int j = 0; j < 5; j++) if (addr == a_of(j)) begin sel = 1; k = j; end
    w1c = (we && sel && k == 3) ? wdata[3:0] : 4'h0;
    for (int i = 0; i < 4; i++)
      nxt[i] = m_mode[i] ? ((m_pend[i] && !w1c[i]) || (s[i] && !m_sprev[i])) : s[i];
    rd = '0;
    if (sel && !we) begin
      case (k)
        0: rd[3:0] = m_en;
        1: rd[3:0] = m_mode;
        2: rd[3:0] = m_pol;
        3: rd[3:0] = m_pend;
        default: rd[3:0] = s;
      endcase
    end
    @(posedge clk);
    #1;
    if (we && sel) begin
      case (k)
        0: m_en = wdata[3:0];
        1: m_mode = wdata[3:0];
        2: m_pol = wdata[3:0];
        default: ;
      endcase
    end
    m_pend = nxt;
    m_sprev = s;
    m_data = rd;
    void'(m_hist.pop_front());
    m_hist.push_back(irq_smp);
  endtask

  task automatic do_reset();
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; irq = '0;
    #2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] v);
    addr = a; wdata = v; we = 1'b1;
    tick();
    we = 1'b0; addr = '0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] v);
    addr = a; we = 1'b0;
    tick();
    v = rdata;
    addr = '0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      rd(a_of(k), v);
      n_checks++;
      if (v !== 16'h0) begin
        n_fail++; $display("FAIL reset_read[%0d]: got %h want 0000", k, v);
      end
    end
    // Mid-run reset with all lines pending and a read in flight
    wr(a_of(1), 16'hF);
    wr(a_of(0), 16'hF);
    irq = 4'hF;
    repeat (4) tick();
    n_checks++;
    if (ext !== 4'hF) begin n_fail++; $display("FAIL pre_reset_ext: got %h want f", ext); end
    addr = a_of(3);
    tick();
    n_checks++;
    if (rdata !== 16'h000F) begin
      n_fail++; $display("FAIL pre_reset_read: got %h want 000f", rdata);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (ext !== 4'h0) begin n_fail++; $display("FAIL reset_async_ext: got %h want 0", ext); end
    n_checks++;
    if (rdata !== 16'h0) begin
      n_fail++; $display("FAIL reset_async_data: got %h want 0000", rdata);
    end
    irq = '0; addr = '0; we = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      rd(a_of(k), v);
      n_checks++;
      if (v !== 16'h0) begin
        n_fail++; $display("FAIL post_reset_read[%0d]: got %h want 0000", k, v);
      end
    end
  endtask

  task automatic test_edge();
    do_reset();
    wr(a_of(0), 16'h1);
    wr(a_of(1), 16'h1);
    irq[0] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_checks++;
      if (ext[0] !== (c == 3)) begin
        n_fail++; $display("FAIL edge_latency c%0d: got %b want %b", c, ext[0], (c == 3));
      end
    end
    wr(a_of(3), 16'h1);
    n_checks++;
    if (ext[0] !== 1'b0) begin n_fail++; $display("FAIL edge_w1c: got %b want 0", ext[0]); end
    repeat (5) begin
      tick();
      n_checks++;
      if (ext[0] !== 1'b0) begin
        n_fail++; $display("FAIL edge_no_reassert: got %b want 0", ext[0]);
      end
    end
  endtask

  task automatic test_level_low();
    do_reset();
    wr(a_of(2), 16'h4);
    wr(a_of(0), 16'h4);
    tick();
    n_checks++;
    if (ext !== 4'h4) begin n_fail++; $display("FAIL level_assert: got %h want 4", ext); end
    wr(a_of(3), 16'h4);
    n_checks++;
    if (ext !== 4'h4) begin n_fail++; $display("FAIL level_w1c: got %h want 4", ext); end
    tick();
    n_checks++;
    if (ext !== 4'h4) begin n_fail++; $display("FAIL level_w1c_hold: got %h want 4", ext); end
    irq[2] = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      n_checks++;
      if (ext[2] !== (c < 3)) begin
        n_fail++; $display("FAIL level_release c%0d: got %b want %b", c, ext[2], (c < 3));
      end
    end
  endtask

  task automatic test_collision();
    do_reset();
    wr(a_of(0), 16'h2);
    wr(a_of(1), 16'h2);
    irq[1] = 1'b1;
    tick();
    tick();
    wr(a_of(3), 16'h2);
    n_checks++;
    if (ext !== 4'h2) begin n_fail++; $display("FAIL collision_set_wins: got %h want 2", ext); end
    wr(a_of(3), 16'h2);
    n_checks++;
    if (ext !== 4'h0) begin n_fail++; $display("FAIL collision_later_clr: got %h want 0", ext); end
  endtask

  task automatic test_masking();
    logic [15:0] v;
    do_reset();
    wr(a_of(1), 16'h8);
    irq[3] = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (ext !== 4'h0) begin n_fail++; $display("FAIL mask_off: got %h want 0", ext); end
    rd(a_of(3), v);
    n_checks++;
    if (v !== 16'h0008) begin n_fail++; $display("FAIL mask_pending: got %h want 0008", v); end
    wr(a_of(0), 16'h8);
    n_checks++;
    if (ext !== 4'h8) begin n_fail++; $display("FAIL mask_enable: got %h want 8", ext); end
  endtask

  task automatic test_decode();
    logic [15:0] v;
    do_reset();
    rd(Base + 16'd1, v);
    n_checks++;
    if (v !== 16'h0) begin n_fail++; $display("FAIL decode_misaligned: got %h want 0000", v); end
    rd(Base + 16'd10, v);
    n_checks++;
    if (v !== 16'h0) begin n_fail++; $display("FAIL decode_range: got %h want 0000", v); end
    wr(Base + 16'd1, 16'hFFFF);
    rd(a_of(0), v);
    n_checks++;
    if (v !== 16'h0) begin n_fail++; $display("FAIL decode_bad_write: got %h want 0000", v); end
    wr(a_of(0), 16'hFFFF);
    rd(a_of(0), v);
    n_checks++;
    if (v !== 16'h000F) begin n_fail++; $display("FAIL decode_enable_rb: got %h want 000f", v); end
    addr = a_of(0); wdata = 16'h000F; we = 1'b1;
    tick();
    we = 1'b0; addr = '0;
    n_checks++;
    if (rdata !== 16'h0) begin n_fail++; $display("FAIL decode_read_on_wr: got %h want 0000", rdata); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      we = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) != 0) addr = a_of($urandom_range(0, 4));
      else addr = 16'($urandom);
      wdata = 16'($urandom);
      if ($urandom_range(0, 3) == 0) irq = irq ^ 4'($urandom);
      tick();
      n_checks++;
      if (ext !== (m_pend & m_en)) begin
        n_fail++; $display("FAIL rand_ext c%0d: got %h want %h", c, ext, m_pend & m_en);
      end
      n_checks++;
      if (rdata !== m_data) begin
        n_fail++; $display("FAIL rand_data c%0d: got %h want %h", c, rdata, m_data);
      end
    end
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; addr = '0; wdata = '0; irq = '0;
    model_reset();
    test_reset();
    test_edge();
    test_level_low();
    test_collision();
    test_masking();
    test_decode();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
